ternary_dest_tracker: RTL and testbench
=======================================

// Module: ternary_dest_tracker
// PURPOSE
//  Tracks destination-register info of in-flight instructions through the ID->EX->MEM->WB pipeline.
//  Supplies the ex_*/mem_* fields that the hazard detection unit consumes, and the wb_* fields for regfile write.
//  Honours id_ex_flush (load-use bubble), br_flush (taken branch) and mem_stall (global freeze).
//  Keeps saturating/wrapping performance counters of stall and flush cycles. Uses ternary_pkg (trit_t, T_ZERO).
// PARAMETERS
//  CNT_W     16  width of stall_count / flush_count
//  SATURATE  1   1: counters saturate at all-ones; 0: counters wrap to 0
// PORTS
//  clk            in   1           core clock, all state on rising edge
//  rst            in   1           asynchronous, active-high reset
//  id_valid       in   1           ID stage holds a valid instruction
//  id_rd          in   trit_t[2:0] ID destination register address
//  id_reg_write   in   1           ID instruction writes rd
//  id_mem_read    in   1           ID instruction is a load
//  id_ex_flush    in   1           insert bubble into EX (load-use stall)
//  br_flush       in   1           taken branch resolved; kill the ID instruction
//  mem_stall      in   1           freeze all tracker stages this cycle
//  clr_counters   in   1           synchronous clear of both counters
//  ex_rd          out  trit_t[2:0] EX destination register
//  ex_reg_write   out  1           EX will write a non-R0 register
//  ex_mem_read    out  1           EX is a valid load
//  mem_rd         out  trit_t[2:0] MEM destination register
//  mem_reg_write  out  1           MEM will write a non-R0 register
//  wb_rd          out  trit_t[2:0] WB destination register
//  wb_reg_write   out  1           WB writes a non-R0 register
//  stall_count    out  CNT_W       count of committed load-use bubbles
//  flush_count    out  CNT_W       count of committed branch flushes
// BEHAVIOUR
//  - State per stage S in {EX,MEM,WB}: valid, rd, rw, mr.
//  - Every output is registered. No combinational path from input to output.
//  - Reset (async, immediate): all valid/rw/mr = 0; all rd = {T_ZERO,T_ZERO,T_ZERO}; both counters = 0.
//  - Qualified outputs: S_reg_write = S_valid & S_rw & (S_rd != R0). ex_mem_read = ex_valid & ex_mr.
//    The rd outputs are passed through unqualified.
//  - Update priority per edge: rst > mem_stall > flush > normal advance.
//  - mem_stall=1: every stage and both counters hold. clr_counters is also ignored.
//  - Otherwise, all stages shift together: WB<=MEM, MEM<=EX.
//    - EX takes a bubble (valid=0, rd=R0, rw=mr=0) if id_ex_flush | br_flush | !id_valid.
//    - Else EX<={1,id_rd,id_reg_write,id_mem_read}.
//  - Latency: ID->ex_* is 1 cycle, ex_*->mem_* is 1 cycle, mem_*->wb_* is 1 cycle.
//    A bubble inserted in EX appears at MEM one cycle later and at WB two cycles later.
//  - Counters, evaluated only when mem_stall=0:
//    - clr_counters=1: both counters become 0 (takes priority over increment).
//    - br_flush=1: flush_count+1. stall_count is not incremented even if id_ex_flush=1.
//    - id_ex_flush=1 & br_flush=0: stall_count+1.
//    - At all-ones: SATURATE=1 holds the value; SATURATE=0 wraps to 0.
//  - A non-canonical trit encoding on id_rd is stored unchanged. It never matches R0, so writes stay enabled.
//  - Reset asserted mid-stream clears all in-flight entries.
//    After deassertion, the first edge loads EX from ID as normal.
// TESTING
//  T1 async reset: pipe full of R1 writes, assert rst between edges
//     -> all reg_write/mem_read = 0, rd = R0, counters = 0 before the next edge.
//  T2 load-use: cycle0 ID = load rd={0,0,+}.
//     -> edge1: ex_rd={0,0,+}, ex_mem_read=1.
//     Then id_ex_flush=1 -> edge2: ex_reg_write=0, mem_rd={0,0,+}, mem_reg_write=1, stall_count=1.
//  T3 freeze: mem_stall=1 for 3 cycles with id_ex_flush=1, br_flush=1, clr_counters=1
//     -> all outputs and counters unchanged across the 3 edges.
//  T4 simultaneous: id_ex_flush=1 & br_flush=1 for one cycle
//     -> single bubble in EX, flush_count +1, stall_count unchanged.
//  T5 saturation: CNT_W=4, 20 consecutive id_ex_flush cycles
//     -> SATURATE=1: stall_count=15; SATURATE=0: stall_count=4.
//  T6 R0 write: id_rd=R0, id_reg_write=1
//     -> ex/mem/wb_reg_write stay 0 as it propagates; wb_rd=R0 after 3 edges.

Source files
------------

// File: rtl/ternary_dest_tracker.sv
// Destination-register tracker for the ternary core's EX/MEM/WB stages.
// Feeds hazard detection (ex_*/mem_*), regfile writeback (wb_*) and stall/flush perf counters.
package ternary_pkg;
    typedef logic [1:0] trit_t;
    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b10;
endpackage

module ternary_dest_tracker
    import ternary_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  trit_t [2:0]       id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_ex_flush,
    input  logic              br_flush,
    input  logic              mem_stall,
    input  logic              clr_counters,
    output trit_t [2:0]       ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output trit_t [2:0]       mem_rd,
    output logic              mem_reg_write,
    output trit_t [2:0]       wb_rd,
    output logic              wb_reg_write,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam trit_t [2:0] R0 = {T_ZERO, T_ZERO, T_ZERO};

    // rw/mr are held already qualified (valid, non-R0) so every output is a bare flop.
    typedef struct packed {
        logic        valid;
        trit_t [2:0] rd;
        logic        rw;
        logic        mr;
    } stage_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, rd: R0, rw: 1'b0, mr: 1'b0};

    stage_t ex_q, mem_q, wb_q, ex_d;
    logic   ex_bubble;

    assign ex_bubble = id_ex_flush | br_flush | ~id_valid;

    always_comb begin
        ex_d = BUBBLE;
        if (!ex_bubble) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = id_rd;
            // A non-canonical trit never equals T_ZERO, so such an rd keeps its write enable.
            ex_d.rw    = id_reg_write & (id_rd != R0);
            ex_d.mr    = id_mem_read;
        end
    end

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (&v) return SATURATE ? v : '0;
        return v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            stall_count <= '0;
            flush_count <= '0;
        end else if (!mem_stall) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
            if (clr_counters) begin
                stall_count <= '0;
                flush_count <= '0;
            end else if (br_flush) begin
                flush_count <= bump(flush_count);
            end else if (id_ex_flush) begin
                stall_count <= bump(stall_count);
            end
        end
    end

    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.rw;
    assign ex_mem_read   = ex_q.mr;
    assign mem_rd        = mem_q.rd;
    assign mem_reg_write = mem_q.rw;
    assign wb_rd         = wb_q.rd;
    assign wb_reg_write  = wb_q.rw;

endmodule

// File: tb/tb_ternary_dest_tracker.sv
// Directed bench for ternary_dest_tracker: reset, load-use, freeze, flush priority, counters, R0.
module tb_ternary_dest_tracker;
    import ternary_pkg::*;

    localparam trit_t [2:0] R0 = {T_ZERO, T_ZERO, T_ZERO};
    localparam trit_t [2:0] R1 = {T_ZERO, T_ZERO, T_POS};
    localparam trit_t [2:0] R2 = {T_ZERO, T_POS, T_ZERO};
    localparam trit_t [2:0] RX = {2'b11, T_ZERO, T_ZERO};

    logic clk = 1'b0, rst = 1'b1;
    logic id_valid = 0, id_reg_write = 0, id_mem_read = 0;
    logic id_ex_flush = 0, br_flush = 0, mem_stall = 0, clr_counters = 0;
    trit_t [2:0] id_rd = R0;

    trit_t [2:0] ex_rd, mem_rd, wb_rd;
    logic ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
    logic [15:0] stall_count, flush_count;

    trit_t [2:0] s_ex_rd, s_mem_rd, s_wb_rd, w_ex_rd, w_mem_rd, w_wb_rd;
    logic s_exw, s_exm, s_memw, s_wbw, w_exw, w_exm, w_memw, w_wbw;
    logic [3:0] s_stall, s_flush, w_stall, w_flush;

    int tests = 0, failed = 0;

    always #5 clk = ~clk;

    ternary_dest_tracker dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_ex_flush(id_ex_flush), .br_flush(br_flush),
        .mem_stall(mem_stall), .clr_counters(clr_counters),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .stall_count(stall_count), .flush_count(flush_count));

    ternary_dest_tracker #(.CNT_W(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_ex_flush(id_ex_flush), .br_flush(br_flush),
        .mem_stall(mem_stall), .clr_counters(clr_counters),
        .ex_rd(s_ex_rd), .ex_reg_write(s_exw), .ex_mem_read(s_exm),
        .mem_rd(s_mem_rd), .mem_reg_write(s_memw), .wb_rd(s_wb_rd), .wb_reg_write(s_wbw),
        .stall_count(s_stall), .flush_count(s_flush));

    ternary_dest_tracker #(.CNT_W(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_ex_flush(id_ex_flush), .br_flush(br_flush),
        .mem_stall(mem_stall), .clr_counters(clr_counters),
        .ex_rd(w_ex_rd), .ex_reg_write(w_exw), .ex_mem_read(w_exm),
        .mem_rd(w_mem_rd), .mem_reg_write(w_memw), .wb_rd(w_wb_rd), .wb_reg_write(w_wbw),
        .stall_count(w_stall), .flush_count(w_flush));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input trit_t [2:0] rd, input logic rw, input logic mr,
                         input logic sf, input logic bf);
        id_valid = v; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        id_ex_flush = sf; br_flush = bf;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write} !== 4'b0 ||
            {ex_rd, mem_rd, wb_rd} !== {R0, R0, R0} || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            failed++;
            $display("FAIL reset_state flags=%b rd=%h cnt=%0d/%0d exp all zero",
                     {ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write}, {ex_rd, mem_rd, wb_rd},
                     stall_count, flush_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        drive(1, R1, 1, 0, 1, 0); step();
        drive(1, R1, 1, 0, 0, 1); step();
        drive(1, R1, 1, 0, 0, 0); step(); step(); step();
        tests++;
        if ({ex_reg_write, mem_reg_write, wb_reg_write} !== 3'b111 || wb_rd !== R1 ||
            stall_count !== 16'd1 || flush_count !== 16'd1) begin
            failed++;
            $display("FAIL t1_prefill rw=%b wb_rd=%h cnt=%0d/%0d exp 111 %h 1/1",
                     {ex_reg_write, mem_reg_write, wb_reg_write}, wb_rd, stall_count, flush_count, R1);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write} !== 4'b0 ||
            {ex_rd, mem_rd, wb_rd} !== {R0, R0, R0} || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            failed++;
            $display("FAIL t1_async_clear flags=%b rd=%h cnt=%0d/%0d exp all zero",
                     {ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write}, {ex_rd, mem_rd, wb_rd},
                     stall_count, flush_count);
        end
        #1 rst = 1'b0;
        drive(0, R0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        drive(1, R1, 1, 1, 0, 0); step();
        tests++;
        if (ex_rd !== R1 || ex_mem_read !== 1'b1 || ex_reg_write !== 1'b1) begin
            failed++;
            $display("FAIL t2_edge1 ex_rd=%h mr=%b rw=%b exp %h 1 1", ex_rd, ex_mem_read, ex_reg_write, R1);
        end
        drive(1, R2, 1, 0, 1, 0); step();
        tests++;
        if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== R0 ||
            mem_rd !== R1 || mem_reg_write !== 1'b1 || stall_count !== 16'd1 || flush_count !== 16'd0) begin
            failed++;
            $display("FAIL t2_edge2 ex=%b%b/%h mem=%h/%b cnt=%0d/%0d exp 00/%h %h/1 1/0",
                     ex_reg_write, ex_mem_read, ex_rd, mem_rd, mem_reg_write, stall_count, flush_count, R0, R1);
        end
    endtask

    task automatic test_freeze();
        drive(1, R2, 1, 1, 1, 1);
        mem_stall = 1'b1; clr_counters = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (ex_rd !== R0 || {ex_reg_write, ex_mem_read} !== 2'b00 || mem_rd !== R1 ||
                mem_reg_write !== 1'b1 || wb_rd !== R0 || wb_reg_write !== 1'b0 ||
                stall_count !== 16'd1 || flush_count !== 16'd0) begin
                failed++;
                $display("FAIL t3_hold_%0d ex=%h mem=%h/%b wb=%h/%b cnt=%0d/%0d exp %h %h/1 %h/0 1/0",
                         i, ex_rd, mem_rd, mem_reg_write, wb_rd, wb_reg_write, stall_count, flush_count,
                         R0, R1, R0);
            end
        end
        mem_stall = 1'b0; clr_counters = 1'b0;
    endtask

    task automatic test_simultaneous();
        drive(1, R2, 1, 0, 0, 0); step();
        tests++;
        if (ex_rd !== R2 || ex_reg_write !== 1'b1 || mem_reg_write !== 1'b0 || wb_rd !== R1 ||
            wb_reg_write !== 1'b1) begin
            failed++;
            $display("FAIL t4_advance ex=%h/%b mem_rw=%b wb=%h/%b exp %h/1 0 %h/1",
                     ex_rd, ex_reg_write, mem_reg_write, wb_rd, wb_reg_write, R2, R1);
        end
        drive(1, R1, 1, 1, 1, 1); step();
        tests++;
        if (ex_rd !== R0 || {ex_reg_write, ex_mem_read} !== 2'b00 || mem_rd !== R2 ||
            mem_reg_write !== 1'b1 || flush_count !== 16'd1 || stall_count !== 16'd1) begin
            failed++;
            $display("FAIL t4_both_flush ex=%h/%b%b mem=%h/%b cnt=%0d/%0d exp %h/00 %h/1 1/1",
                     ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, stall_count, flush_count, R0, R2);
        end
        drive(0, R0, 0, 0, 0, 0); step();
        tests++;
        if (mem_reg_write !== 1'b0 || mem_rd !== R0 || wb_rd !== R2 || wb_reg_write !== 1'b1) begin
            failed++;
            $display("FAIL t4_bubble_mem mem=%h/%b wb=%h/%b exp %h/0 %h/1",
                     mem_rd, mem_reg_write, wb_rd, wb_reg_write, R0, R2);
        end
        step();
        tests++;
        if (wb_reg_write !== 1'b0 || wb_rd !== R0) begin
            failed++;
            $display("FAIL t4_bubble_wb wb=%h/%b exp %h/0", wb_rd, wb_reg_write, R0);
        end
    endtask

    task automatic test_counters();
        clr_counters = 1'b1; drive(0, R0, 0, 0, 1, 1); step();
        clr_counters = 1'b0;
        tests++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0 || s_stall !== 4'd0 || w_stall !== 4'd0) begin
            failed++;
            $display("FAIL t5_clear cnt=%0d/%0d s=%0d w=%0d exp 0", stall_count, flush_count, s_stall, w_stall);
        end
        drive(1, R1, 1, 0, 1, 0);
        for (int i = 0; i < 20; i++) step();
        tests++;
        if (s_stall !== 4'd15) begin
            failed++;
            $display("FAIL t5_saturate stall=%0d exp 15", s_stall);
        end
        tests++;
        if (w_stall !== 4'd4) begin
            failed++;
            $display("FAIL t5_wrap stall=%0d exp 4", w_stall);
        end
        tests++;
        if (stall_count !== 16'd20 || flush_count !== 16'd0) begin
            failed++;
            $display("FAIL t5_wide cnt=%0d/%0d exp 20/0", stall_count, flush_count);
        end
    endtask

    task automatic test_r0_write();
        drive(1, R0, 1, 1, 0, 0); step();
        tests++;
        if (ex_reg_write !== 1'b0 || ex_rd !== R0 || ex_mem_read !== 1'b1) begin
            failed++;
            $display("FAIL t6_ex rw=%b rd=%h mr=%b exp 0 %h 1", ex_reg_write, ex_rd, ex_mem_read, R0);
        end
        drive(0, R0, 0, 0, 0, 0); step();
        tests++;
        if (mem_reg_write !== 1'b0) begin
            failed++;
            $display("FAIL t6_mem rw=%b exp 0", mem_reg_write);
        end
        step();
        tests++;
        if (wb_reg_write !== 1'b0 || wb_rd !== R0) begin
            failed++;
            $display("FAIL t6_wb rw=%b rd=%h exp 0 %h", wb_reg_write, wb_rd, R0);
        end
    endtask

    task automatic test_noncanonical();
        drive(1, RX, 1, 0, 0, 0); step();
        drive(0, R0, 0, 0, 0, 0);
        tests++;
        if (ex_rd !== RX || ex_reg_write !== 1'b1) begin
            failed++;
            $display("FAIL nc_ex rd=%h rw=%b exp %h 1", ex_rd, ex_reg_write, RX);
        end
        step(); step();
        tests++;
        if (wb_rd !== RX || wb_reg_write !== 1'b1) begin
            failed++;
            $display("FAIL nc_wb rd=%h rw=%b exp %h 1", wb_rd, wb_reg_write, RX);
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_load_use();
        test_freeze();
        test_simultaneous();
        test_counters();
        test_r0_write();
        test_noncanonical();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
